microwave_timer: RTL and testbench

- Cook-time countdown that sits directly upstream of the microwave door/heat controller and produces its `finish` input.
- Accepts keypad buttons to set time in minutes and seconds.
- Counts down once per second only while the controller drives `heat` high, and freezes when `heat` drops (door-open pause).
- Exposes remaining mm:ss in binary for a separate display decoder.

---
 rtl/microwave_pkg.sv | 13 +
 rtl/btn_pulse.sv | 28 ++
 rtl/microwave_timer.sv | 125 ++++++++++++
 tb/tb_microwave_timer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared time-of-day types for the microwave countdown and its display decoder.
// mmss_t carries minutes/seconds in plain binary.
package microwave_pkg;

    localparam int SEC_PER_MIN = 60;
    localparam int SEC_MAX     = 59;

    typedef struct packed {
        logic [6:0] min;
        logic [5:0] sec;
    } mmss_t;

endpackage

// File: rtl/btn_pulse.sv
// Raw keypad level -> 2-FF synchroniser -> single-cycle pulse on the rising edge.
// The pulse is combinational from the last two flops, so it is consumed on the third edge after the raw rise.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown: keypad sets mm:ss, counts down once per second while heat is high,
// and pulses finish to the heat controller when the time runs out.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter int MAX_MIN  = 99,
    parameter int SEC_STEP = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add_min,
    input  logic       add_sec,
    input  logic       clear,
    input  logic       heat,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       finish
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_DIV - 1);

    logic [2:0] w_raw;
    logic [2:0] w_pulse;

    assign w_raw = {clear, add_sec, add_min};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_pulse u_btn (
                .clk   (clk),
                .rst   (rst),
                .in    (w_raw[gi]),
                .pulse (w_pulse[gi])
            );
        end
    endgenerate

    logic w_add_min_p;
    logic w_add_sec_p;
    logic w_clear_p;

    assign w_add_min_p = w_pulse[0];
    assign w_add_sec_p = w_pulse[1];
    assign w_clear_p   = w_pulse[2];

    mmss_t         r_time;
    logic [PW-1:0] r_presc;
    logic          r_heat_q;
    logic          r_finish;

    logic       w_zero;
    logic       w_tick;
    logic       w_clear_now;
    logic [7:0] w_min;
    logic [7:0] w_sec;
    logic       w_next_zero;

    assign w_zero      = (r_time.min == 7'd0) && (r_time.sec == 6'd0);
    assign w_tick      = heat && !w_zero && (r_presc == PRESC_TC);
    assign w_clear_now = w_clear_p && !heat;

    // 8-bit scratch so a carry past 127 minutes is still seen by the saturation check.
    always_comb begin
        w_min = {1'b0, r_time.min};
        w_sec = {2'b0, r_time.sec};
        if (w_clear_now) begin
            w_min = 8'd0;
            w_sec = 8'd0;
        end else begin
            if (w_tick) begin
                if (w_sec == 8'd0) begin
                    w_sec = 8'(SEC_MAX);
                    w_min = w_min - 8'd1;
                end else begin
                    w_sec = w_sec - 8'd1;
                end
            end
            if (w_add_min_p) begin
                w_min = w_min + 8'd1;
            end
            if (w_add_sec_p) begin
                w_sec = w_sec + 8'(SEC_STEP);
                if (w_sec >= 8'(SEC_PER_MIN)) begin
                    w_sec = w_sec - 8'(SEC_PER_MIN);
                    w_min = w_min + 8'd1;
                end
            end
            if (w_min > 8'(MAX_MIN)) begin
                w_min = 8'(MAX_MIN);
                w_sec = 8'(SEC_MAX);
            end
        end
    end

    assign w_next_zero = (w_min == 8'd0) && (w_sec == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time   <= '0;
            r_presc  <= '0;
            r_heat_q <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_time.min <= w_min[6:0];
            r_time.sec <= w_sec[5:0];
            r_heat_q   <= heat;
            // Partial second is kept across a heat=0 pause; only clear or an empty timer resets it.
            if (w_clear_now || w_zero) begin
                r_presc <= '0;
            end else if (heat) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
            r_finish <= (w_tick && w_next_zero) || (heat && !r_heat_q && w_zero);
        end
    end

    assign minutes = r_time.min;
    assign seconds = r_time.sec;
    assign running = heat && !w_zero;
    assign finish  = r_finish;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed checks for microwave_timer with a 4-cycle second: vector table plus
// hand-written pause, saturation, coincident-add and async-reset sequences.
module tb_microwave_timer;

    logic       clk;
    logic       rst;
    logic       add_min;
    logic       add_sec;
    logic       clear;
    logic       heat;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       finish;

    int n_pass;
    int n_total;

    microwave_timer #(
        .CLK_DIV  (4),
        .MAX_MIN  (99),
        .SEC_STEP (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .add_min (add_min),
        .add_sec (add_sec),
        .clear   (clear),
        .heat    (heat),
        .minutes (minutes),
        .seconds (seconds),
        .running (running),
        .finish  (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic am;
        logic as;
        logic cl;
        logic ht;
        int   n;
        int   emin;
        int   esec;
        int   erun;
        int   efin;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_time(input string name, input int m, input int s);
        check({name, " min"}, int'(minutes), m);
        check({name, " sec"}, int'(seconds), s);
    endtask

    // which: 0=add_min 1=add_sec 2=clear; held 4 cycles to confirm a single pulse
    task automatic press(input int which);
        if (which == 0) add_min = 1'b1;
        else if (which == 1) add_sec = 1'b1;
        else clear = 1'b1;
        step(4);
        add_min = 1'b0;
        add_sec = 1'b0;
        clear   = 1'b0;
        step(1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        add_min = 1'b0;
        add_sec = 1'b0;
        clear   = 1'b0;
        heat    = 1'b0;

        //          am  as  cl  ht   n  min sec run fin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 0,  0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   5, 1,  0, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,   2, 1,  0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,   5, 2,  0, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0,   2, 2,  0, 0, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,   5, 2, 10, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 100, 2, 10, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0,   5, 0,  0, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,   2, 0,  0, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0,   5, 0, 10, 0, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0,   2, 0, 10, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1,  32, 0,  2, 1, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1,   3, 0,  2, 1, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 0,  1, 1, 0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1,   3, 0,  1, 1, 0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 0,  0, 0, 1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 0,  0, 0, 0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1,  20, 0,  0, 0, 0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0,   2, 0,  0, 0, 0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 0,  0, 0, 1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 0,  0, 0, 0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1,  10, 0,  0, 0, 0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 0,  0, 0, 0};

        step(3);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            add_min = tbl[i].am;
            add_sec = tbl[i].as;
            clear   = tbl[i].cl;
            heat    = tbl[i].ht;
            step(tbl[i].n);
            check($sformatf("vec%0d min", i), int'(minutes), tbl[i].emin);
            check($sformatf("vec%0d sec", i), int'(seconds), tbl[i].esec);
            check($sformatf("vec%0d running", i), int'(running), tbl[i].erun);
            check($sformatf("vec%0d finish", i), int'(finish), tbl[i].efin);
            $display("vec%0d am=%0b as=%0b cl=%0b ht=%0b n=%0d -> %0d:%0d run=%0b fin=%0b",
                     i, tbl[i].am, tbl[i].as, tbl[i].cl, tbl[i].ht, tbl[i].n,
                     minutes, seconds, running, finish);
        end

        // Pause keeps the partial second
        press(1);
        heat = 1'b1;
        step(20);
        heat = 1'b0;
        step(2);
        check_time("pause start", 0, 5);
        heat = 1'b1;
        step(3);
        check_time("pause pre-tick", 0, 5);
        step(1);
        check_time("pause first tick", 0, 4);
        step(2);
        heat = 1'b0;
        step(20);
        check_time("pause frozen", 0, 4);
        check("pause running", int'(running), 0);
        heat = 1'b1;
        step(1);
        check_time("resume +1", 0, 4);
        step(1);
        check_time("resume +2", 0, 3);
        heat = 1'b0;
        step(1);
        press(2);
        check_time("pause clear", 0, 0);
        $display("pause sequence done -> %0d:%0d", minutes, seconds);

        // Saturation at MAX_MIN:59
        for (int k = 0; k < 99; k++) press(0);
        check_time("99 min", 99, 0);
        press(0);
        check_time("min saturate", 99, 59);
        heat = 1'b1;
        step(16);
        heat = 1'b0;
        check_time("count to 99:55", 99, 55);
        press(1);
        check_time("sec saturate", 99, 59);
        press(0);
        check_time("min at max", 99, 59);
        heat  = 1'b1;
        clear = 1'b1;
        step(3);
        heat = 1'b0;
        check_time("clear while heat", 99, 59);
        check("clear while heat finish", int'(finish), 0);
        clear = 1'b0;
        step(2);
        press(2);
        check_time("clear idle", 0, 0);
        $display("saturation sequence done -> %0d:%0d", minutes, seconds);

        // add_min lands on the final tick
        press(1);
        heat = 1'b1;
        step(36);
        check_time("coinc 00:01", 0, 1);
        step(1);
        add_min = 1'b1;
        step(3);
        check_time("coinc result", 1, 0);
        check("coinc finish", int'(finish), 0);
        check("coinc running", int'(running), 1);
        step(1);
        check("coinc finish late", int'(finish), 0);
        add_min = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        check_time("async rst", 0, 0);
        check("async rst running", int'(running), 0);
        check("async rst finish", int'(finish), 0);
        step(2);
        rst  = 1'b0;
        heat = 1'b0;
        step(1);
        check_time("after rst", 0, 0);
        $display("coincident/reset sequence done -> %0d:%0d", minutes, seconds);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
